// File: rtl/mu0_pkg.sv
// Shared definitions for the MU0 controller and datapath: FSM states,
// opcode values and ALU mode encodings.
package mu0_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_EXECUTE = 2'd2,
        ST_HALT    = 2'd3
    } state_t;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_STO = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_JGE = 4'h5;
    localparam logic [3:0] OP_JNE = 4'h6;
    localparam logic [3:0] OP_STP = 4'h7;

    localparam logic [1:0] M_Y   = 2'b00;
    localparam logic [1:0] M_ADD = 2'b01;
    localparam logic [1:0] M_INC = 2'b10;
    localparam logic [1:0] M_SUB = 2'b11;

    // STP and every opcode from 8 upwards end execution.
    function automatic logic is_stop_op(input logic [3:0] f);
        return f[3] || (f == OP_STP);
    endfunction

endpackage

// File: rtl/mu0_decode.sv
// Combinational control decode: turns the current state, opcode, flags and
// memory handshake into every datapath select, enable and memory strobe.
module mu0_decode
    import mu0_pkg::*;
(
    input  state_t     state,
    input  logic [3:0] F,
    input  logic       N,
    input  logic       Z,
    input  logic       Mem_Ready,
    output logic       X_sel,
    output logic       Y_sel,
    output logic       Addr_sel,
    output logic       PC_En,
    output logic       IR_En,
    output logic       Acc_En,
    output logic [1:0] M,
    output logic       Rd,
    output logic       Wr,
    output logic       exec_done
);

    // Selects and strobes depend only on state/opcode so they hold steady
    // through wait states; enables follow Mem_Ready so they fire once.
    always_comb begin
        X_sel     = 1'b0;
        Y_sel     = 1'b0;
        Addr_sel  = 1'b0;
        PC_En     = 1'b0;
        IR_En     = 1'b0;
        Acc_En    = 1'b0;
        M         = M_Y;
        Rd        = 1'b0;
        Wr        = 1'b0;
        exec_done = 1'b0;
        case (state)
            ST_FETCH: begin
                Rd    = 1'b1;
                X_sel = 1'b1;
                M     = M_INC;
                IR_En = Mem_Ready;
                PC_En = Mem_Ready;
            end
            ST_EXECUTE: begin
                case (F)
                    OP_LDA: begin
                        Addr_sel  = 1'b1;
                        Rd        = 1'b1;
                        Acc_En    = Mem_Ready;
                        exec_done = Mem_Ready;
                    end
                    OP_STO: begin
                        Addr_sel  = 1'b1;
                        Wr        = 1'b1;
                        exec_done = Mem_Ready;
                    end
                    OP_ADD: begin
                        Addr_sel  = 1'b1;
                        Rd        = 1'b1;
                        M         = M_ADD;
                        Acc_En    = Mem_Ready;
                        exec_done = Mem_Ready;
                    end
                    OP_SUB: begin
                        Addr_sel  = 1'b1;
                        Rd        = 1'b1;
                        M         = M_SUB;
                        Acc_En    = Mem_Ready;
                        exec_done = Mem_Ready;
                    end
                    OP_JMP: begin
                        Y_sel     = 1'b1;
                        PC_En     = 1'b1;
                        exec_done = 1'b1;
                    end
                    OP_JGE: begin
                        Y_sel     = 1'b1;
                        PC_En     = !N;
                        exec_done = 1'b1;
                    end
                    OP_JNE: begin
                        Y_sel     = 1'b1;
                        PC_En     = !Z;
                        exec_done = 1'b1;
                    end
                    default: begin
                        // STP and illegal opcodes: no datapath activity.
                        exec_done = 1'b1;
                    end
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mu0_control.sv
// MU0 sequencing controller: fetch/execute FSM with run/step control,
// halt/illegal status and a retired-instruction counter.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   ST_IDLE    | stopped; waits for Run or Step to start a fetch
//   ST_FETCH   | reading instruction at PC into IR, PC <= PC+1
//   ST_EXECUTE | carrying out the opcode in IR; retires it on completion
//   ST_HALT    | stopped by STP or an illegal opcode; left only by Reset
module mu0_control
    import mu0_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic [3:0]  F,
    input  logic        N,
    input  logic        Z,
    input  logic        Mem_Ready,
    input  logic        Run,
    input  logic        Step,
    output logic        X_sel,
    output logic        Y_sel,
    output logic        Addr_sel,
    output logic        PC_En,
    output logic        IR_En,
    output logic        Acc_En,
    output logic [1:0]  M,
    output logic        Rd,
    output logic        Wr,
    output logic        Halted,
    output logic        Illegal,
    output logic [15:0] Instr_count
);

    state_t state;
    state_t state_nxt;
    logic   exec_done;

    mu0_decode u_decode (
        .state     (state),
        .F         (F),
        .N         (N),
        .Z         (Z),
        .Mem_Ready (Mem_Ready),
        .X_sel     (X_sel),
        .Y_sel     (Y_sel),
        .Addr_sel  (Addr_sel),
        .PC_En     (PC_En),
        .IR_En     (IR_En),
        .Acc_En    (Acc_En),
        .M         (M),
        .Rd        (Rd),
        .Wr        (Wr),
        .exec_done (exec_done)
    );

    // State register; reset abandons any access in flight.
    always_ff @(posedge Clk) begin
        if (Reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic. Run is looked at again after every instruction, so
    // dropping it lets the current instruction finish before idling.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (Run || Step) state_nxt = ST_FETCH;
            ST_FETCH:   if (Mem_Ready) state_nxt = ST_EXECUTE;
            ST_EXECUTE: begin
                if (exec_done) begin
                    if (is_stop_op(F)) state_nxt = ST_HALT;
                    else if (Run)      state_nxt = ST_FETCH;
                    else               state_nxt = ST_IDLE;
                end
            end
            ST_HALT:    state_nxt = ST_HALT;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Status flags and retired count; stopping opcodes retire too.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Halted      <= 1'b0;
            Illegal     <= 1'b0;
            Instr_count <= 16'h0000;
        end else if (state == ST_EXECUTE && exec_done) begin
            Instr_count <= Instr_count + 16'h0001;
            if (is_stop_op(F)) Halted  <= 1'b1;
            if (F[3])          Illegal <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mu0_control.sv
// Self-checking bench for mu0_control: a behavioural MU0 datapath and memory
// with programmable wait states around the DUT, an instruction-level model
// of MU0 for end results, and per-cycle control expectations by phase.
module tb_mu0_control;

    localparam int P_IDLE = 0;
    localparam int P_FETCH = 1;
    localparam int P_EXEC = 2;
    localparam int P_HALT = 3;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Run = 1'b0;
    logic        Step = 1'b0;
    logic [3:0]  F;
    logic        N, Z, Mem_Ready;
    logic        X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En, Rd, Wr;
    logic [1:0]  M;
    logic        Halted, Illegal;
    logic [15:0] Instr_count;

    mu0_control dut (
        .Clk(Clk), .Reset(Reset), .F(F), .N(N), .Z(Z), .Mem_Ready(Mem_Ready),
        .Run(Run), .Step(Step), .X_sel(X_sel), .Y_sel(Y_sel), .Addr_sel(Addr_sel),
        .PC_En(PC_En), .IR_En(IR_En), .Acc_En(Acc_En), .M(M), .Rd(Rd), .Wr(Wr),
        .Halted(Halted), .Illegal(Illegal), .Instr_count(Instr_count)
    );

    always #5 Clk = ~Clk;

    // ---------------- behavioural datapath and memory ----------------
    logic [15:0] mem     [0:4095];
    logic [15:0] prog    [0:4095];
    logic [15:0] ref_mem [0:4095];
    logic [11:0] pc;
    logic [15:0] ir, acc, alu;
    logic        load = 1'b0;
    int          wcnt;
    int          wait_n = 0;

    wire [11:0] addr    = Addr_sel ? ir[11:0] : pc;
    wire [15:0] data_in = mem[addr];
    wire [15:0] x_val   = X_sel ? {4'h0, pc} : acc;
    wire [15:0] y_val   = Y_sel ? ir : data_in;

    always_comb begin
        alu = y_val;
        case (M)
            2'b01: alu = x_val + y_val;
            2'b10: alu = x_val + 16'd1;
            2'b11: alu = x_val - y_val;
            default: alu = y_val;
        endcase
    end

    assign F = ir[15:12];
    assign N = acc[15];
    assign Z = (acc == 16'h0000);
    assign Mem_Ready = (Rd || Wr) && (wcnt == wait_n);

    always @(posedge Clk) begin
        if (load) mem <= prog;
        else if (Wr && Mem_Ready) mem[addr] <= acc;
        if (Reset) begin
            pc <= 12'h000; ir <= 16'h0000; acc <= 16'h0000; wcnt <= 0;
        end else begin
            if (IR_En)  ir  <= data_in;
            if (PC_En)  pc  <= alu[11:0];
            if (Acc_En) acc <= alu;
            if ((Rd || Wr) && !Mem_Ready) wcnt <= wcnt + 1;
            else wcnt <= 0;
        end
    end

    // ---------------- checking state ----------------
    int          checks = 0;
    int          errors = 0;
    int          ph = P_IDLE;
    logic [15:0] exp_count = 16'h0000;
    logic        exp_halted = 1'b0;
    logic        exp_illegal = 1'b0;
    int          last_ticks;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [9:0] ctl_vec();
        return {X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En, M, Rd, Wr};
    endfunction

    // One clock: sample inputs, advance the phase model by the documented
    // sequencing rules, then compare every output to its expected value.
    task automatic tick();
        logic c_rst, c_run, c_step, c_rdy;
        logic [3:0] c_op;
        logic [9:0] e;
        logic r;
        logic mem_op;
        #2;
        c_rst = Reset; c_run = Run; c_step = Step; c_rdy = Mem_Ready; c_op = ir[15:12];
        @(posedge Clk);
        #1;
        mem_op = (c_op == 4'h0) || (c_op == 4'h1) || (c_op == 4'h2) || (c_op == 4'h3);
        if (c_rst) begin
            ph = P_IDLE; exp_count = 16'h0000; exp_halted = 1'b0; exp_illegal = 1'b0;
        end else begin
            case (ph)
                P_IDLE:  if (c_run || c_step) ph = P_FETCH;
                P_FETCH: if (c_rdy) ph = P_EXEC;
                P_EXEC: begin
                    if (!mem_op || c_rdy) begin
                        exp_count = exp_count + 16'd1;
                        if (c_op >= 4'h7) begin
                            ph = P_HALT;
                            exp_halted = 1'b1;
                            if (c_op >= 4'h8) exp_illegal = 1'b1;
                        end else begin
                            ph = c_run ? P_FETCH : P_IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end
        r = Mem_Ready;
        e = 10'b0;
        if (ph == P_FETCH) e = {1'b1, 1'b0, 1'b0, r, r, 1'b0, 2'b10, 1'b1, 1'b0};
        else if (ph == P_EXEC) begin
            case (ir[15:12])
                4'h0: e = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, r, 2'b00, 1'b1, 1'b0};
                4'h1: e = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1};
                4'h2: e = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, r, 2'b01, 1'b1, 1'b0};
                4'h3: e = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, r, 2'b11, 1'b1, 1'b0};
                4'h4: e = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
                4'h5: e = {1'b0, 1'b1, 1'b0, !acc[15], 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
                4'h6: e = {1'b0, 1'b1, 1'b0, acc != 16'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
                default: e = 10'b0;
            endcase
        end
        check("ctl", 32'(ctl_vec()), 32'(e));
        check("count", 32'(Instr_count), 32'(exp_count));
        check("halted", 32'(Halted), 32'(exp_halted));
        check("illegal", 32'(Illegal), 32'(exp_illegal));
    endtask

    task automatic do_reset();
        load = 1'b1; Reset = 1'b1; Run = 1'b0; Step = 1'b0;
        tick();
        load = 1'b0; Reset = 1'b0;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 4096; i++) prog[i] = 16'h0000;
    endtask

    // Instruction-level MU0 interpreter; cycles follow 1 cycle per access
    // plus the wait states, 1 cycle for non-memory executes.
    task automatic isa_run(input int w, output int cnt, output int cyc,
                           output logic ill, output logic [15:0] a);
        logic [11:0] p;
        logic [15:0] ins;
        logic done;
        int guard;
        for (int i = 0; i < 4096; i++) ref_mem[i] = prog[i];
        p = 12'h0; a = 16'h0; cnt = 0; cyc = 0; ill = 1'b0; done = 1'b0; guard = 0;
        while (!done && guard < 10000) begin
            ins = ref_mem[p];
            p = p + 12'd1;
            cnt++; guard++;
            cyc += 1 + w;
            case (ins[15:12])
                4'h0: begin a = ref_mem[ins[11:0]]; cyc += 1 + w; end
                4'h1: begin ref_mem[ins[11:0]] = a; cyc += 1 + w; end
                4'h2: begin a = a + ref_mem[ins[11:0]]; cyc += 1 + w; end
                4'h3: begin a = a - ref_mem[ins[11:0]]; cyc += 1 + w; end
                4'h4: begin p = ins[11:0]; cyc += 1; end
                4'h5: begin if (!a[15]) p = ins[11:0]; cyc += 1; end
                4'h6: begin if (a != 16'h0) p = ins[11:0]; cyc += 1; end
                4'h7: begin done = 1'b1; cyc += 1; end
                default: begin done = 1'b1; ill = 1'b1; cyc += 1; end
            endcase
        end
    endtask

    task automatic run_program(input int w, input string tag);
        int m_cnt, m_cyc, bad, t;
        logic m_ill;
        logic [15:0] m_acc;
        wait_n = w;
        do_reset();
        Run = 1'b1;
        t = 0;
        while (Halted !== 1'b1 && t < 3000) begin
            tick();
            t++;
        end
        Run = 1'b0;
        last_ticks = t;
        isa_run(w, m_cnt, m_cyc, m_ill, m_acc);
        check({tag, "_ticks"}, 32'(t), 32'(1 + m_cyc));
        check({tag, "_count"}, 32'(Instr_count), 32'(m_cnt));
        check({tag, "_illegal"}, 32'(Illegal), 32'(m_ill));
        check({tag, "_acc"}, 32'(acc), 32'(m_acc));
        bad = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) bad++;
        check({tag, "_mem"}, 32'(bad), 32'd0);
    endtask

    task automatic load_prog_a();
        clear_prog();
        prog[0] = 16'h0010; prog[1] = 16'h2011; prog[2] = 16'h1012; prog[3] = 16'h7000;
        prog[12'h010] = 16'd5; prog[12'h011] = 16'd7;
    endtask

    initial begin
        int t, k;
        int unsigned op, ea;

        // Reset state
        clear_prog();
        wait_n = 0;
        do_reset();
        check("rst_ctl", 32'(ctl_vec()), 32'd0);
        check("rst_count", 32'(Instr_count), 32'd0);
        check("rst_halted", 32'(Halted), 32'd0);
        check("rst_illegal", 32'(Illegal), 32'd0);

        // LDA/ADD/STO/STP, zero and two wait states
        load_prog_a();
        run_program(0, "progA_w0");
        check("progA_w0_sum", 32'(mem[12'h012]), 32'd12);
        check("progA_w0_cycles", 32'(last_ticks - 1), 32'd8);
        check("progA_w0_n", 32'(Instr_count), 32'd4);
        run_program(2, "progA_w2");
        check("progA_w2_sum", 32'(mem[12'h012]), 32'd12);
        check("progA_w2_cycles", 32'(last_ticks - 1), 32'd22);

        // JNE with Acc=0: not taken
        clear_prog();
        prog[0] = 16'h0010; prog[1] = 16'h6020; prog[2] = 16'h7000;
        prog[12'h010] = 16'h0000; prog[12'h020] = 16'hF000;
        run_program(1, "jne_zero");
        check("jne_zero_not_taken", 32'(Illegal), 32'd0);

        // JGE with Acc=0x8000: not taken; with Acc=5: taken into illegal
        prog[1] = 16'h5020; prog[12'h010] = 16'h8000;
        run_program(0, "jge_neg");
        check("jge_neg_not_taken", 32'(Illegal), 32'd0);
        prog[12'h010] = 16'h0005;
        run_program(0, "jge_pos");
        check("jge_pos_taken", 32'(Illegal), 32'd1);

        // JMP 0x0A0: next fetch comes from 0x0A0
        clear_prog();
        prog[0] = 16'h40A0; prog[12'h0A0] = 16'h7000;
        wait_n = 0;
        do_reset();
        Run = 1'b1;
        tick(); tick(); tick();
        check("jmp_fetch_rd", 32'(Rd), 32'd1);
        check("jmp_fetch_addr", 32'(addr), 32'h0A0);
        t = 0;
        while (Halted !== 1'b1 && t < 50) begin tick(); t++; end
        Run = 1'b0;
        check("jmp_halted", 32'(Halted), 32'd1);
        check("jmp_count", 32'(Instr_count), 32'd2);

        // Illegal opcode 0x9
        clear_prog();
        prog[0] = 16'h9123;
        run_program(1, "ill9");
        check("ill9_halted", 32'(Halted), 32'd1);
        check("ill9_illegal", 32'(Illegal), 32'd1);
        check("ill9_count", 32'(Instr_count), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("ill9_no_rd", 32'(Rd), 32'd0);
        end

        // Single Step pulse
        load_prog_a();
        wait_n = 0;
        do_reset();
        Step = 1'b1;
        tick();
        Step = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("step_count", 32'(Instr_count), 32'd1);
        check("step_idle_ctl", 32'(ctl_vec()), 32'd0);
        check("step_acc", 32'(acc), 32'd5);

        // Step held: one instruction per 3 cycles
        do_reset();
        Step = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        Step = 1'b0;
        check("step_held_count", 32'(Instr_count), 32'd3);
        check("step_held_sum", 32'(mem[12'h012]), 32'd12);

        // Run dropped mid-instruction
        wait_n = 1;
        do_reset();
        Run = 1'b1;
        tick(); tick(); tick();
        Run = 1'b0;
        tick(); tick();
        check("run_drop_count", 32'(Instr_count), 32'd1);
        tick();
        check("run_drop_idle_rd", 32'(Rd), 32'd0);
        check("run_drop_still", 32'(Instr_count), 32'd1);

        // Reset during a waited FETCH
        wait_n = 3;
        do_reset();
        Run = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("rst_mid_count_before", 32'(Instr_count), 32'd1);
        check("rst_mid_rd_before", 32'(Rd), 32'd1);
        Reset = 1'b1; Run = 1'b0;
        tick();
        Reset = 1'b0;
        check("rst_mid_rd", 32'(Rd), 32'd0);
        check("rst_mid_count", 32'(Instr_count), 32'd0);
        check("rst_mid_ctl", 32'(ctl_vec()), 32'd0);

        // Random forward-jumping programs against the instruction model
        for (int n = 0; n < 20; n++) begin
            clear_prog();
            k = int'($urandom_range(4, 12));
            for (int i = 0; i < k; i++) begin
                op = $urandom_range(0, 6);
                if (op >= 4) ea = $urandom_range(i + 1, k);
                else ea = 32'h80 + $urandom_range(0, 15);
                prog[i] = {op[3:0], ea[11:0]};
            end
            op = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 15) : 32'd7;
            prog[k] = {op[3:0], 12'h000};
            for (int j = 0; j < 16; j++) prog[128 + j] = 16'($urandom);
            run_program(int'($urandom_range(0, 2)), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
